// File: rtl/dual_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dual_core_mem_arbiter
// Brief    : Shares one single-port byte memory between two multicycle cores.
//            Round-robin grant, one-cycle issue, fixed read latency and a
//            one-cycle done pulse back to the granted core.
// Revision : 1.0 - initial release
// ============================================================================
module dual_core_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1    // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    // core 0
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_done,
    // core 1
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_done,
    // shared memory
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // debug
    output logic              owner,
    output logic              busy
);

    localparam logic [3:0] c_LATENCY = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c0_rdata;
    logic [DATA_W-1:0] r_c1_rdata;
    logic [3:0]        r_cnt;

    logic              w_grant_c1;
    logic              w_issue;

    // Core 1 wins when it is alone, or on a tie when core 0 went last.
    always_comb begin
        w_grant_c1 = c1_req && (!c0_req || (r_last_owner == 1'b0));
    end

    // Arbitration FSM: latches the winner's operands at grant, counts the
    // memory latency and captures read data on the last wait cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_c0_rdata   <= '0;
            r_c1_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (c0_req || c1_req) begin
                        r_owner <= w_grant_c1;
                        r_we    <= w_grant_c1 ? c1_we    : c0_we;
                        r_addr  <= w_grant_c1 ? c1_addr  : c0_addr;
                        r_wdata <= w_grant_c1 ? c1_wdata : c0_wdata;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= c_LATENCY;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        if (!r_we) begin
                            if (r_owner) begin
                                r_c1_rdata <= mem_rdata;
                            end else begin
                                r_c0_rdata <= mem_rdata;
                            end
                        end
                        r_cnt   <= 4'd0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_last_owner <= r_owner;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory side and completion pulses decode purely from state and
    // latched registers, so no request input reaches the memory pins.
    assign w_issue   = (r_state == S_ISSUE);
    assign mem_en    = w_issue;
    assign mem_we    = w_issue && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign c0_done   = (r_state == S_RESP) && !r_owner;
    assign c1_done   = (r_state == S_RESP) &&  r_owner;
    assign c0_rdata  = r_c0_rdata;
    assign c1_rdata  = r_c1_rdata;

    assign owner     = r_owner;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
